// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// This block shares the single register-file write port between two sources:
// the in-order pipeline write-back stage and a long-latency (LL) unit. Results
// from the LL unit are queued in a small FIFO.
//
// Arbitration:
//   * A WB request normally wins the port, and the FIFO head drains only in
//     idle WB cycles.
//   * If the head is denied for STARVE_LIMIT consecutive cycles, the FSM
//     enters HOLD for one cycle. In that cycle the head is forced out and the
//     WB write is stalled, so MEM/WB freezes and re-presents the write.
//
// Valid/ready on the LL side:
//   * A transfer completes on a rising edge where LL_Valid and LL_Ready are
//     both 1.
//   * LL_Ready depends only on the registered occupancy, so a pop in the same
//     cycle never makes room for that cycle's transfer.
//   * Transfers to r0 complete but are dropped.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  // pipeline write-back request
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  // long-latency unit result handshake
  input  logic        LL_Valid,
  input  logic [4:0]  LL_WriteReg,
  input  logic [31:0] LL_WriteData,
  output logic        LL_Ready,
  // register-file write port
  output logic        RF_WriteEn,
  output logic [4:0]  RF_WriteReg,
  output logic [31:0] RF_WriteData,
  // pipeline freeze request for the current WB write
  output logic        WB_Stall,
  // decode-stage scoreboard query
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  output logic        Hazard,
  // debug view of the arbiter FSM (1 = HOLD)
  output logic        Dbg_Hold
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_HOLD   = 1'b1
  } state_t;

  state_t state_q;

  // FIFO storage and bookkeeping
  logic [4:0]    wreg_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic fifo_empty;
  logic fifo_full;
  logic wb_req;
  logic push;
  logic pop;
  logic grant_wb;
  logic grant_head;
  logic starve_trip;
  logic hazard_fifo;
  logic hazard_push;
  logic [AW-1:0] hz_idx;

  function automatic logic reg_hit(input logic [4:0] r,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign wb_req     = WB_RegWrite && (WB_WriteReg != 5'd0);
  assign LL_Ready   = !fifo_full;
  assign push       = LL_Valid && LL_Ready && (LL_WriteReg != 5'd0);
  assign pop        = grant_head;
  assign Dbg_Hold   = (state_q == ST_HOLD);

  // Port arbitration: HOLD forces the head out, otherwise WB has priority
  always_comb begin
    grant_wb   = 1'b0;
    grant_head = 1'b0;
    WB_Stall   = 1'b0;
    if ((state_q == ST_HOLD) && !fifo_empty) begin
      grant_head = 1'b1;
      WB_Stall   = wb_req;
    end else if (wb_req) begin
      grant_wb = 1'b1;
    end else if (!fifo_empty) begin
      grant_head = 1'b1;
    end
  end

  // Register-file write port mux; drives zeros when nobody writes
  always_comb begin
    RF_WriteEn   = 1'b0;
    RF_WriteReg  = 5'd0;
    RF_WriteData = 32'd0;
    if (grant_wb) begin
      RF_WriteEn   = 1'b1;
      RF_WriteReg  = WB_WriteReg;
      RF_WriteData = WB_WriteData;
    end else if (grant_head) begin
      RF_WriteEn   = 1'b1;
      RF_WriteReg  = wreg_q[rd_ptr_q];
      RF_WriteData = wdata_q[rd_ptr_q];
    end
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starve counter: counts denied cycles of a waiting head, saturating
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Trip on the edge where the counter reaches the limit
  assign starve_trip = !fifo_empty && !pop && (starve_q >= SW'(STARVE_LIMIT - 1));

  // Scoreboard lookup.
  // The head being written this cycle is excluded: its value lands in the
  // register file on the same edge that decode reads it.
  // A transfer being accepted this cycle is included.
  always_comb begin
    hazard_fifo = 1'b0;
    hz_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hz_idx = rd_ptr_q + AW'(k);
      if ((CW'(k) < count_q) && !((k == 0) && pop) &&
          reg_hit(wreg_q[hz_idx], ID_Rs, ID_Rt)) begin
        hazard_fifo = 1'b1;
      end
    end
  end

  assign hazard_push = push && reg_hit(LL_WriteReg, ID_Rs, ID_Rt);
  assign Hazard      = hazard_fifo || hazard_push;

  // Arbiter FSM: HOLD lasts until exactly one forced pop (or an empty FIFO)
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_NORMAL;
    end else begin
      case (state_q)
        ST_NORMAL: if (starve_trip) state_q <= ST_HOLD;
        ST_HOLD:   if (fifo_empty || pop) state_q <= ST_NORMAL;
      endcase
    end
  end

  // FIFO control and starve counter registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // FIFO payload storage; validity comes from the occupancy count only
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      wreg_q[wr_ptr_q]  <= LL_WriteReg;
      wdata_q[wr_ptr_q] <= LL_WriteData;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        LL_Valid;
  logic [4:0]  LL_WriteReg;
  logic [31:0] LL_WriteData;
  logic        LL_Ready;
  logic        RF_WriteEn;
  logic [4:0]  RF_WriteReg;
  logic [31:0] RF_WriteData;
  logic        WB_Stall;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        Hazard;
  logic        Dbg_Hold;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .Clk(Clk), .Rst(Rst),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .LL_Valid(LL_Valid), .LL_WriteReg(LL_WriteReg), .LL_WriteData(LL_WriteData),
    .LL_Ready(LL_Ready),
    .RF_WriteEn(RF_WriteEn), .RF_WriteReg(RF_WriteReg), .RF_WriteData(RF_WriteData),
    .WB_Stall(WB_Stall), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .Hazard(Hazard),
    .Dbg_Hold(Dbg_Hold)
  );

  // ---------------- reference model ----------------
  // Pending LL results in arrival order, {reg, data}
  logic [36:0] exp_q[$];
  bit          m_hold;
  int          m_starve;
  bit          m_push, m_pop;
  logic        exp_ready, exp_en, exp_stall, exp_hazard, exp_hold;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;

  function automatic bit hits(input logic [4:0] r);
    return (r != 5'd0) && ((r == ID_Rs) || (r == ID_Rt));
  endfunction

  task automatic model_eval();
    bit          wbreq;
    int          n;
    logic [36:0] e;
    wbreq      = WB_RegWrite && (WB_WriteReg != 5'd0);
    n          = exp_q.size();
    exp_ready  = (n < DEPTH);
    m_push     = LL_Valid && exp_ready && (LL_WriteReg != 5'd0);
    m_pop      = 1'b0;
    exp_en     = 1'b0;
    exp_reg    = 5'd0;
    exp_data   = 32'd0;
    exp_stall  = 1'b0;
    exp_hold   = m_hold;
    if (m_hold && n > 0) begin
      m_pop     = 1'b1;
      exp_stall = wbreq;
    end else if (wbreq) begin
      exp_en   = 1'b1;
      exp_reg  = WB_WriteReg;
      exp_data = WB_WriteData;
    end else if (n > 0) begin
      m_pop = 1'b1;
    end
    if (m_pop) begin
      e        = exp_q[0];
      exp_en   = 1'b1;
      exp_reg  = e[36:32];
      exp_data = e[31:0];
    end
    exp_hazard = 1'b0;
    for (int j = (m_pop ? 1 : 0); j < n; j++) begin
      e = exp_q[j];
      if (hits(e[36:32])) exp_hazard = 1'b1;
    end
    if (m_push && hits(LL_WriteReg)) exp_hazard = 1'b1;
  endtask

  // Advance one clock, updating the model with the pre-edge decisions
  task automatic tick();
    bit nonempty;
    model_eval();
    @(posedge Clk);
    if (Rst) begin
      exp_q.delete();
      m_hold   = 1'b0;
      m_starve = 0;
    end else begin
      nonempty = (exp_q.size() > 0);
      if (m_hold) m_hold = 1'b0;
      else if (nonempty && !m_pop && (m_starve + 1 >= STARVE_LIMIT)) m_hold = 1'b1;
      if (!nonempty || m_pop) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({LL_WriteReg, LL_WriteData});
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    WB_RegWrite  = 1'b0;
    WB_WriteReg  = 5'd0;
    WB_WriteData = 32'd0;
    LL_Valid     = 1'b0;
    LL_WriteReg  = 5'd0;
    LL_WriteData = 32'd0;
    ID_Rs        = 5'd0;
    ID_Rt        = 5'd0;
  endtask

  task automatic do_reset();
    set_idle();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    WB_RegWrite  = en;
    WB_WriteReg  = r;
    WB_WriteData = d;
  endtask

  task automatic drive_ll(input logic v, input logic [4:0] r, input logic [31:0] d);
    LL_Valid     = v;
    LL_WriteReg  = r;
    LL_WriteData = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    Rst = 1'b1;
    tick();
    tick();
    Rst   = 1'b0;
    ID_Rs = 5'd7;
    ID_Rt = 5'd9;
    #1;
    checks++;
    if (LL_Ready !== 1'b1) begin
      errors++; $display("FAIL reset_ll_ready got=%b exp=1", LL_Ready);
    end
    checks++;
    if (RF_WriteEn !== 1'b0) begin
      errors++; $display("FAIL reset_rf_en got=%b exp=0", RF_WriteEn);
    end
    checks++;
    if (WB_Stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b exp=0", WB_Stall);
    end
    checks++;
    if (Hazard !== 1'b0) begin
      errors++; $display("FAIL reset_hazard got=%b exp=0", Hazard);
    end
    checks++;
    if (Dbg_Hold !== 1'b0) begin
      errors++; $display("FAIL reset_state got=%b exp=0", Dbg_Hold);
    end
    tick();
  endtask

  task automatic test_wb_write();
    do_reset();
    drive_wb(1'b1, 5'd5, 32'h1234);
    #1;
    checks++;
    if ({RF_WriteEn, RF_WriteReg, RF_WriteData, WB_Stall} !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin
      errors++;
      $display("FAIL wb_write got en=%b reg=%0d data=%h stall=%b exp en=1 reg=5 data=1234 stall=0",
               RF_WriteEn, RF_WriteReg, RF_WriteData, WB_Stall);
    end
    tick();
    set_idle();
  endtask

  task automatic test_ll_single();
    do_reset();
    ID_Rs = 5'd7;
    drive_ll(1'b1, 5'd7, 32'hAA);
    #1;
    checks++;
    if ({Hazard, RF_WriteEn, LL_Ready} !== 3'b101) begin
      errors++; $display("FAIL ll_push_cycle got hz=%b en=%b rdy=%b exp hz=1 en=0 rdy=1",
                         Hazard, RF_WriteEn, LL_Ready);
    end
    tick();
    drive_ll(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({RF_WriteEn, RF_WriteReg, RF_WriteData} !== {1'b1, 5'd7, 32'hAA}) begin
      errors++; $display("FAIL ll_write got en=%b reg=%0d data=%h exp en=1 reg=7 data=aa",
                         RF_WriteEn, RF_WriteReg, RF_WriteData);
    end
    checks++;
    if (Hazard !== 1'b0) begin
      errors++; $display("FAIL ll_hazard_drop got=%b exp=0", Hazard);
    end
    tick();
    checks++;
    if ({RF_WriteEn, Hazard} !== 2'b00) begin
      errors++; $display("FAIL ll_after got en=%b hz=%b exp 00", RF_WriteEn, Hazard);
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_ll(1'b1, 5'd4, 32'd1);
    tick();
    drive_ll(1'b1, 5'd4, 32'd2);
    #1;
    checks++;
    if ({RF_WriteEn, RF_WriteReg, RF_WriteData} !== {1'b1, 5'd4, 32'd1}) begin
      errors++; $display("FAIL dup_first got en=%b reg=%0d data=%0d exp 1/4/1",
                         RF_WriteEn, RF_WriteReg, RF_WriteData);
    end
    tick();
    drive_ll(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if ({RF_WriteEn, RF_WriteReg, RF_WriteData} !== {1'b1, 5'd4, 32'd2}) begin
      errors++; $display("FAIL dup_second got en=%b reg=%0d data=%0d exp 1/4/2",
                         RF_WriteEn, RF_WriteReg, RF_WriteData);
    end
    tick();
    checks++;
    if (RF_WriteEn !== 1'b0) begin
      errors++; $display("FAIL dup_drained got en=%b exp 0", RF_WriteEn);
    end
  endtask

  task automatic test_r0();
    do_reset();
    drive_ll(1'b1, 5'd0, 32'h55);
    drive_wb(1'b1, 5'd0, 32'h66);
    #1;
    checks++;
    if ({LL_Ready, RF_WriteEn, Hazard, WB_Stall} !== 4'b1000) begin
      errors++; $display("FAIL r0_cycle got rdy=%b en=%b hz=%b stall=%b exp 1000",
                         LL_Ready, RF_WriteEn, Hazard, WB_Stall);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if ({LL_Ready, RF_WriteEn} !== 2'b10) begin
      errors++; $display("FAIL r0_no_push got rdy=%b en=%b exp rdy=1 en=0", LL_Ready, RF_WriteEn);
    end
    tick();
  endtask

  task automatic test_starve();
    do_reset();
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_ll(1'b1, 5'd9, 32'h99);
    tick();
    drive_ll(1'b0, 5'd0, 32'd0);
    for (int c = 1; c <= STARVE_LIMIT; c++) begin
      #1;
      checks++;
      if ({Dbg_Hold, WB_Stall, RF_WriteEn, RF_WriteReg} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin
        errors++; $display("FAIL starve_wait c=%0d got hold=%b stall=%b en=%b reg=%0d exp 0/0/1/3",
                           c, Dbg_Hold, WB_Stall, RF_WriteEn, RF_WriteReg);
      end
      tick();
    end
    #1;
    checks++;
    if ({Dbg_Hold, WB_Stall, RF_WriteEn, RF_WriteReg, RF_WriteData} !==
        {1'b1, 1'b1, 1'b1, 5'd9, 32'h99}) begin
      errors++; $display("FAIL starve_hold got hold=%b stall=%b en=%b reg=%0d data=%h exp 1/1/1/9/99",
                         Dbg_Hold, WB_Stall, RF_WriteEn, RF_WriteReg, RF_WriteData);
    end
    tick();
    checks++;
    if ({Dbg_Hold, WB_Stall, RF_WriteEn, RF_WriteReg, RF_WriteData} !==
        {1'b0, 1'b0, 1'b1, 5'd3, 32'h33}) begin
      errors++; $display("FAIL starve_release got hold=%b stall=%b en=%b reg=%0d data=%h exp 0/0/1/3/33",
                         Dbg_Hold, WB_Stall, RF_WriteEn, RF_WriteReg, RF_WriteData);
    end
    tick();
    set_idle();
  endtask

  task automatic test_fill();
    bit accepted;
    int n14;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_wb(1'b1, 5'd1, $urandom);
      drive_ll(1'b1, 5'(10 + i), $urandom);
      #1;
      checks++;
      if (LL_Ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready i=%0d got=%b exp=1", i, LL_Ready);
      end
      tick();
    end
    drive_wb(1'b1, 5'd1, $urandom);
    drive_ll(1'b1, 5'd14, 32'hE14);
    ID_Rs = 5'd12;
    #1;
    checks++;
    if ({LL_Ready, Hazard} !== 2'b01) begin
      errors++; $display("FAIL fill_full got rdy=%b hz=%b exp rdy=0 hz=1", LL_Ready, Hazard);
    end
    accepted = 1'b0;
    for (int c = 0; c < 40 && !accepted; c++) begin
      drive_wb(1'b1, 5'd1, $urandom);
      #1;
      model_eval();
      checks++;
      if ({LL_Ready, RF_WriteEn, RF_WriteReg, RF_WriteData, WB_Stall} !==
          {exp_ready, exp_en, exp_reg, exp_data, exp_stall}) begin
        errors++; $display("FAIL fill_hold c=%0d got rdy=%b en=%b reg=%0d data=%h stall=%b exp %b %b %0d %h %b",
                           c, LL_Ready, RF_WriteEn, RF_WriteReg, RF_WriteData, WB_Stall,
                           exp_ready, exp_en, exp_reg, exp_data, exp_stall);
      end
      accepted = LL_Ready;
      tick();
    end
    checks++;
    if (!accepted) begin
      errors++; $display("FAIL fill_accept got=timeout exp=accepted");
    end
    set_idle();
    n14 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      model_eval();
      checks++;
      if ({RF_WriteEn, RF_WriteReg, RF_WriteData} !== {exp_en, exp_reg, exp_data}) begin
        errors++; $display("FAIL fill_drain c=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h",
                           c, RF_WriteEn, RF_WriteReg, RF_WriteData, exp_en, exp_reg, exp_data);
      end
      if (RF_WriteEn === 1'b1 && RF_WriteReg === 5'd14 && RF_WriteData === 32'hE14) n14++;
      tick();
    end
    checks++;
    if (n14 != 1) begin
      errors++; $display("FAIL fill_held_entry got=%0d writes exp=1", n14);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_wb(1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 3; i++) begin
      drive_ll(1'b1, 5'(20 + i), 32'hD0 + 32'(i));
      tick();
    end
    set_idle();
    Rst = 1'b1;
    tick();
    Rst   = 1'b0;
    ID_Rs = 5'd20;
    ID_Rt = 5'd22;
    #1;
    checks++;
    if ({LL_Ready, RF_WriteEn, Hazard, Dbg_Hold} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid got rdy=%b en=%b hz=%b hold=%b exp 1000",
                         LL_Ready, RF_WriteEn, Hazard, Dbg_Hold);
    end
    tick();
    checks++;
    if (RF_WriteEn !== 1'b0) begin
      errors++; $display("FAIL rst_mid_nowrite got en=%b reg=%0d exp en=0", RF_WriteEn, RF_WriteReg);
    end
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      Rst = ($urandom_range(0, 149) == 0);
      drive_wb($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom);
      drive_ll($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      ID_Rs = 5'($urandom_range(0, 7));
      ID_Rt = 5'($urandom_range(0, 7));
      #1;
      model_eval();
      checks++;
      if ({LL_Ready, WB_Stall, Hazard, Dbg_Hold} !== {exp_ready, exp_stall, exp_hazard, exp_hold}) begin
        errors++; $display("FAIL rand_ctrl c=%0d got rdy/stall/hz/hold=%b%b%b%b exp=%b%b%b%b",
                           c, LL_Ready, WB_Stall, Hazard, Dbg_Hold,
                           exp_ready, exp_stall, exp_hazard, exp_hold);
      end
      checks++;
      if ({RF_WriteEn, RF_WriteReg, RF_WriteData} !== {exp_en, exp_reg, exp_data}) begin
        errors++; $display("FAIL rand_rf c=%0d got en=%b reg=%0d data=%h exp en=%b reg=%0d data=%h",
                           c, RF_WriteEn, RF_WriteReg, RF_WriteData, exp_en, exp_reg, exp_data);
      end
      tick();
    end
    Rst = 1'b0;
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_hold   = 1'b0;
    m_starve = 0;
    Rst      = 1'b1;
    set_idle();
    test_reset();
    test_wb_write();
    test_ll_single();
    test_back_to_back();
    test_r0();
    test_starve();
    test_fill();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
